// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks
//   uart_state_t  receiver FSM encoding
//   PAR_*         parity-mode constants
//   calc_div      clock cycles per oversample tick
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_ovs.sv
// uart_baud_ovs: oversample tick generator
//   clk    clock
//   reset  synchronous, active-low reset
//   clr    synchronous clear, holds the counter at 0
//   ost    one-cycle pulse when the 0..DIV-1 counter wraps
module uart_baud_ovs #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic ost
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;
    logic         wrap;

    assign wrap = (cnt_q == W'(DIV - 1));
    assign ost  = wrap & ~clr;

    always_ff @(posedge clk) begin
        if (!reset || clr) cnt_q <= '0;
        else cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with majority vote and valid/ready output
//   clk, reset          clock, synchronous active-low reset
//   rxd                 asynchronous serial line, idle high
//   rx_data/perr/ferr   presented frame and its error flags
//   rx_valid, rx_ready  frame handshake
//   overrun             one-cycle pulse when a frame is dropped
//   busy                frame reception in progress
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int OVS         = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
    localparam int MID = OVS / 2;
    localparam int SW  = $clog2(OVS);

    if (OVS < 8 || OVS % 2 != 0 || DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_rx_ovs: parameter out of range");
    end

    uart_state_t          state_q;
    logic [1:0]           sync_q;
    logic [SW-1:0]        sc_q;
    logic [3:0]           bc_q;
    logic                 s0_q, s1_q, arm_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q, frm_err_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, rx_perr_q, rx_ferr_q, overrun_q, busy_q;
    logic                 rxd_s, ost, maj, vote, bit_end, last_stop, ferr_n, accept;

    uart_baud_ovs #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == IDLE),
        .ost   (ost)
    );

    assign rxd_s     = sync_q[1];
    // third vote sample is the live line at sc = MID+1
    assign maj       = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);
    assign vote      = ost && sc_q == SW'(MID + 1);
    assign bit_end   = ost && sc_q == SW'(OVS - 1);
    // leave at the vote point of the last stop bit so a back-to-back start edge is caught
    assign last_stop = state_q == STOP && vote && bc_q == 4'(STOP_BITS - 1);
    assign ferr_n    = frm_err_q | ~maj;
    assign accept    = !rx_valid_q || rx_ready;

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_perr  = rx_perr_q;
    assign rx_ferr  = rx_ferr_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q     <= 2'b11;
            state_q    <= IDLE;
            sc_q       <= '0;
            bc_q       <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            arm_q      <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rxd};
            overrun_q <= 1'b0;
            if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
            if (ost) sc_q <= bit_end ? '0 : sc_q + 1'b1;
            if (ost && sc_q == SW'(MID - 1)) s0_q <= rxd_s;
            if (ost && sc_q == SW'(MID)) s1_q <= rxd_s;
            case (state_q)
                IDLE: begin
                    // arm_q keeps a held-low line (break) from starting another frame
                    if (rxd_s) arm_q <= 1'b1;
                    else if (arm_q) begin
                        state_q   <= START;
                        busy_q    <= 1'b1;
                        bc_q      <= '0;
                        par_err_q <= 1'b0;
                        frm_err_q <= 1'b0;
                    end
                end
                START: begin
                    if (vote && maj) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        sc_q    <= '0;
                    end else if (bit_end) state_q <= DATA;
                end
                DATA: begin
                    if (vote) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                    if (bit_end) begin
                        bc_q <= (bc_q == 4'(DATA_BITS - 1)) ? '0 : bc_q + 1'b1;
                        if (bc_q == 4'(DATA_BITS - 1)) state_q <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (vote) par_err_q <= (^shift_q ^ maj) != (PARITY_MODE == PAR_ODD);
                    if (bit_end) state_q <= STOP;
                end
                STOP: begin
                    if (vote) frm_err_q <= ferr_n;
                    if (last_stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        arm_q   <= 1'b0;
                        sc_q    <= '0;
                    end else if (bit_end) bc_q <= bc_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (last_stop) begin
                if (accept) begin
                    rx_data_q  <= shift_q;
                    rx_perr_q  <= par_err_q;
                    rx_ferr_q  <= ferr_n;
                    rx_valid_q <= 1'b1;
                end else overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: randomized and directed bench for uart_rx_ovs (8N1, 8E1 and 9N2 instances)
module tb_uart_rx_ovs;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rdy = 1'b1;
    logic       line = 1'b1;
    int         sel = 0;
    logic [2:0] rxd, v, pe, fe, ov, bz;
    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic [8:0] od [3];
    logic [12:0] cap[$];
    logic [12:0] exp_q[$];
    int nchk = 0, nerr = 0, vcyc = 0, ovcnt = 0, bzcnt = 0;

    always #5 clk = ~clk;

    assign rxd[0] = (sel == 0) ? line : 1'b1;
    assign rxd[1] = (sel == 1) ? line : 1'b1;
    assign rxd[2] = (sel == 2) ? line : 1'b1;
    assign od[0]  = {1'b0, d0};
    assign od[1]  = {1'b0, d1};
    assign od[2]  = d2;

    uart_rx_ovs #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .OVS(16)) u0 (
        .clk(clk), .reset(reset), .rxd(rxd[0]), .rx_data(d0), .rx_valid(v[0]), .rx_ready(rdy),
        .rx_perr(pe[0]), .rx_ferr(fe[0]), .overrun(ov[0]), .busy(bz[0]));

    uart_rx_ovs #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .OVS(16), .PARITY_MODE(1)) u1 (
        .clk(clk), .reset(reset), .rxd(rxd[1]), .rx_data(d1), .rx_valid(v[1]), .rx_ready(rdy),
        .rx_perr(pe[1]), .rx_ferr(fe[1]), .overrun(ov[1]), .busy(bz[1]));

    uart_rx_ovs #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .OVS(16), .DATA_BITS(9), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .rxd(rxd[2]), .rx_data(d2), .rx_valid(v[2]), .rx_ready(rdy),
        .rx_perr(pe[2]), .rx_ferr(fe[2]), .overrun(ov[2]), .busy(bz[2]));

    // capture word: {dut, ferr, perr, data}
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (v[k]) vcyc++;
            if (ov[k]) ovcnt++;
            if (bz[k]) bzcnt++;
            if (v[k] && rdy) cap.push_back({2'(k), fe[k], pe[k], od[k]});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wclk(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // serialises one frame for the chosen instance; e is the frame the reference model expects
    task automatic send(input int dut, input logic [8:0] data, input bit bad_par, input bit bad_stop,
                        output logic [12:0] e);
        int nb = (dut == 2) ? 9 : 8;
        int pm = (dut == 1) ? 1 : 0;
        int ns = (dut == 2) ? 2 : 1;
        int ones = 0;
        int bs;
        bit b[$];
        b.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            b.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (pm != 0) b.push_back(bit'(ones % 2) ^ bad_par);
        bs = bad_stop ? int'($urandom_range(0, ns - 1)) : -1;
        for (int s = 0; s < ns; s++) b.push_back(s != bs);
        sel = dut;
        foreach (b[i]) begin
            line = b[i];
            wclk(16);
        end
        e = {2'(dut), bad_stop, (pm != 0) && bad_par, (nb == 8) ? {1'b0, data[7:0]} : data};
    endtask

    task automatic test_reset;
        reset = 1'b0;
        wclk(5);
        nchk++;
        if ({v, pe, fe, ov, bz} !== 15'd0) begin
            nerr++;
            $display("FAIL reset_flags: got %h, want 0", {v, pe, fe, ov, bz});
        end
        nchk++;
        if ({d0, d1, d2} !== 25'd0) begin
            nerr++;
            $display("FAIL reset_data: got %h, want 0", {d0, d1, d2});
        end
        reset = 1'b1;
        wclk(5);
    endtask

    task automatic test_8n1;
        logic [12:0] e;
        int vc0 = vcyc, ov0 = ovcnt;
        cap.delete();
        rdy = 1'b1;
        send(0, 9'h055, 1'b0, 1'b0, e);
        line = 1'b1;
        wclk(20);
        nchk++;
        if (cap.size() !== 1) begin
            nerr++;
            $display("FAIL 8n1_count: got %0d, want 1", cap.size());
        end
        nchk++;
        if ((cap.size() > 0 ? cap[0] : 13'hx) !== {2'd0, 1'b0, 1'b0, 9'h055}) begin
            nerr++;
            $display("FAIL 8n1_frame: got %h, want %h", cap.size() > 0 ? cap[0] : 13'hx, {2'd0, 2'b00, 9'h055});
        end
        nchk++;
        if (vcyc - vc0 !== 1) begin
            nerr++;
            $display("FAIL 8n1_valid_width: got %0d, want 1", vcyc - vc0);
        end
        nchk++;
        if (ovcnt - ov0 !== 0) begin
            nerr++;
            $display("FAIL 8n1_overrun: got %0d, want 0", ovcnt - ov0);
        end
    endtask

    task automatic test_parity;
        logic [12:0] e;
        cap.delete();
        send(1, 9'h0A3, 1'b1, 1'b0, e);
        line = 1'b1;
        wclk(20);
        nchk++;
        if ((cap.size() == 1 ? cap[0] : 13'hx) !== {2'd1, 1'b0, 1'b1, 9'h0A3}) begin
            nerr++;
            $display("FAIL parity_err: got %h (n=%0d), want %h", cap.size() > 0 ? cap[0] : 13'hx, cap.size(), {2'd1, 2'b01, 9'h0A3});
        end
    endtask

    task automatic test_break;
        logic [12:0] e;
        cap.delete();
        send(0, 9'h00F, 1'b0, 1'b1, e);
        line = 1'b0;
        wclk(16 * 14);
        nchk++;
        if (cap.size() !== 1) begin
            nerr++;
            $display("FAIL ferr_single: got %0d frames, want 1", cap.size());
        end
        nchk++;
        if ((cap.size() > 0 ? cap[0] : 13'hx) !== {2'd0, 1'b1, 1'b0, 9'h00F}) begin
            nerr++;
            $display("FAIL ferr_frame: got %h, want %h", cap.size() > 0 ? cap[0] : 13'hx, {2'd0, 2'b10, 9'h00F});
        end
        nchk++;
        if (bz[0] !== 1'b0) begin
            nerr++;
            $display("FAIL ferr_idle: busy got %b, want 0", bz[0]);
        end
        line = 1'b1;
        wclk(32);
        cap.delete();
        line = 1'b0;
        wclk(16 * 14);
        nchk++;
        if ((cap.size() == 1 ? cap[0] : 13'hx) !== {2'd0, 1'b1, 1'b0, 9'h000}) begin
            nerr++;
            $display("FAIL break_frame: got %h (n=%0d), want %h", cap.size() > 0 ? cap[0] : 13'hx, cap.size(), {2'd0, 2'b10, 9'h000});
        end
        line = 1'b1;
        wclk(32);
        cap.delete();
        send(0, 9'($urandom), 1'b0, 1'b0, e);
        line = 1'b1;
        wclk(20);
        nchk++;
        if ((cap.size() == 1 ? cap[0] : 13'hx) !== e) begin
            nerr++;
            $display("FAIL break_rearm: got %h (n=%0d), want %h", cap.size() > 0 ? cap[0] : 13'hx, cap.size(), e);
        end
    endtask

    task automatic test_glitch;
        int bz0 = bzcnt, vc0 = vcyc;
        cap.delete();
        sel = 0;
        line = 1'b0;
        wclk(5);
        line = 1'b1;
        wclk(40);
        nchk++;
        if ((bzcnt > bz0) !== 1'b1) begin
            nerr++;
            $display("FAIL glitch_busy_pulse: got %0d busy cycles, want >0", bzcnt - bz0);
        end
        nchk++;
        if (bz[0] !== 1'b0) begin
            nerr++;
            $display("FAIL glitch_idle: busy got %b, want 0", bz[0]);
        end
        nchk++;
        if (vcyc - vc0 !== 0 || cap.size() !== 0) begin
            nerr++;
            $display("FAIL glitch_no_valid: got %0d valid cycles, want 0", vcyc - vc0);
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] e;
        int ov0 = ovcnt;
        cap.delete();
        rdy = 1'b0;
        send(0, 9'h011, 1'b0, 1'b0, e);
        send(0, 9'h022, 1'b0, 1'b0, e);
        line = 1'b1;
        wclk(20);
        nchk++;
        if ({v[0], d0} !== {1'b1, 8'h11}) begin
            nerr++;
            $display("FAIL hold_frame: got valid=%b data=%h, want valid=1 data=11", v[0], d0);
        end
        nchk++;
        if (ovcnt - ov0 !== 1) begin
            nerr++;
            $display("FAIL overrun_pulse: got %0d, want 1", ovcnt - ov0);
        end
        rdy = 1'b1;
        wclk(1);
        nchk++;
        if (v[0] !== 1'b0) begin
            nerr++;
            $display("FAIL valid_drop: got %b, want 0", v[0]);
        end
        nchk++;
        if ((cap.size() == 1 ? cap[0] : 13'hx) !== {2'd0, 2'b00, 9'h011}) begin
            nerr++;
            $display("FAIL held_accept: got %h (n=%0d), want %h", cap.size() > 0 ? cap[0] : 13'hx, cap.size(), {2'd0, 2'b00, 9'h011});
        end
        send(0, 9'($urandom), 1'b0, 1'b0, e);
        line = 1'b1;
        wclk(20);
        nchk++;
        if ((cap.size() == 2 ? cap[1] : 13'hx) !== e) begin
            nerr++;
            $display("FAIL after_overrun: got %h (n=%0d), want %h", cap.size() > 1 ? cap[1] : 13'hx, cap.size(), e);
        end
    endtask

    task automatic test_reset_mid;
        logic [12:0] e;
        rdy = 1'b0;
        send(0, 9'h05A, 1'b0, 1'b0, e);
        line = 1'b1;
        wclk(20);
        sel = 0;
        line = 1'b0;
        wclk(16);
        line = 1'b1;
        wclk(16 * 4 + 8);
        nchk++;
        if (bz[0] !== 1'b1) begin
            nerr++;
            $display("FAIL mid_busy: got %b, want 1", bz[0]);
        end
        reset = 1'b0;
        wclk(2);
        nchk++;
        if ({v, pe, fe, ov, bz, d0} !== 23'd0) begin
            nerr++;
            $display("FAIL mid_reset: got %h, want 0", {v, pe, fe, ov, bz, d0});
        end
        rdy = 1'b1;
        reset = 1'b1;
        wclk(5);
        cap.delete();
        send(0, 9'h03C, 1'b0, 1'b0, e);
        line = 1'b1;
        wclk(20);
        nchk++;
        if ((cap.size() == 1 ? cap[0] : 13'hx) !== {2'd0, 2'b00, 9'h03C}) begin
            nerr++;
            $display("FAIL post_reset: got %h (n=%0d), want %h", cap.size() > 0 ? cap[0] : 13'hx, cap.size(), {2'd0, 2'b00, 9'h03C});
        end
    endtask

    task automatic test_9n2;
        logic [12:0] e;
        cap.delete();
        send(2, 9'h1A5, 1'b0, 1'b0, e);
        line = 1'b1;
        wclk(20);
        nchk++;
        if ((cap.size() == 1 ? cap[0] : 13'hx) !== {2'd2, 2'b00, 9'h1A5}) begin
            nerr++;
            $display("FAIL 9n2_frame: got %h (n=%0d), want %h", cap.size() > 0 ? cap[0] : 13'hx, cap.size(), {2'd2, 2'b00, 9'h1A5});
        end
    endtask

    task automatic test_random;
        logic [12:0] e;
        bit bp, bs;
        cap.delete();
        exp_q.delete();
        rdy = 1'b1;
        for (int n = 0; n < 30; n++) begin
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 3) == 0);
            send(int'($urandom_range(0, 2)), 9'($urandom), bp, bs, e);
            exp_q.push_back(e);
            line = 1'b1;
            wclk(bs ? 40 : int'($urandom_range(0, 20)));
        end
        wclk(20);
        nchk++;
        if (cap.size() !== exp_q.size()) begin
            nerr++;
            $display("FAIL random_count: got %0d, want %0d", cap.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            nchk++;
            if ((i < cap.size() ? cap[i] : 13'hx) !== exp_q[i]) begin
                nerr++;
                $display("FAIL random_frame[%0d]: got %h, want %h", i, i < cap.size() ? cap[i] : 13'hx, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_9n2();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
